muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the ALU. It consumes the same forwarded operand values as the ALU, including the sign- or zero-extended immediate path where applicable. It executes MULT/MULTU/DIV/DIVU with fixed latencies and handles MTHI/MTLO writes. It exposes `busy` so hazard control can stall any HI/LO-dependent instruction in ID.

---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: EX-stage multiply/divide unit owning the architectural HI/LO pair.
// Latency: MULT/MULTU hold busy for MULT_CYCLES cycles and DIV/DIVU for DIV_CYCLES,
//          with HI/LO committed on the edge where busy falls. MTHI/MTLO take effect in one edge.
// Backpressure: none inside the unit. A start seen while busy is dropped, so hazard control must stall.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; aborts any operation in flight
//   start      single-cycle launch pulse for the operation selected by MDOp
//   MDOp[2:0]  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   A[31:0]    rs operand (multiplicand / dividend / MTHI-MTLO source)
//   B[31:0]    rt operand (multiplier / divisor)
//   busy       registered; high while a multiply or divide is in flight
//   HI, LO     registered architectural HI/LO

module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    // Pending result, computed at launch and held until the commit edge.
    logic [31:0]    hi_n_q, hi_n_d;
    logic [31:0]    lo_n_q, lo_n_d;
    // Set when the pending divide had a zero divisor: busy period runs, commit is suppressed.
    logic           dz_q, dz_d;

    // ------------------------------------------------------------------
    // Arithmetic, evaluated combinationally on the launch operands.
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // unsigned multiply equal to the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    logic        b_zero;
    logic [31:0] divisor_u;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // A zero divisor is replaced by 1 so the divider never produces X;
    // the result is discarded at commit anyway.
    assign b_zero    = (B == 32'd0);
    assign divisor_u = b_zero ? 32'd1 : B;
    assign quot_u    = A / divisor_u;
    assign rem_u     = A % divisor_u;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Signed divide on magnitudes. |-2^31| = 0x80000000 is still correct as an
    // unsigned value, so -2^31 / -1 yields quotient 0x80000000, remainder 0
    // without a special case.
    assign abs_a    = A[31] ? (32'd0 - A) : A;
    assign abs_b    = B[31] ? (32'd0 - B) : divisor_u;
    assign quot_mag = abs_a / abs_b;
    assign rem_mag  = abs_a % abs_b;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign quot_s   = (A[31] ^ B[31]) ? (32'd0 - quot_mag) : quot_mag;
    assign rem_s    = A[31] ? (32'd0 - rem_mag) : rem_mag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (MDOp)
                        OP_MULT: begin
                            hi_n_d  = prod_s[63:32];
                            lo_n_d  = prod_s[31:0];
                            dz_d    = 1'b0;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            hi_n_d  = prod_u[63:32];
                            lo_n_d  = prod_u[31:0];
                            dz_d    = 1'b0;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV: begin
                            hi_n_d  = rem_s;
                            lo_n_d  = quot_s;
                            dz_d    = b_zero;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIVU: begin
                            hi_n_d  = rem_u;
                            lo_n_d  = quot_u;
                            dz_d    = b_zero;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                // start is ignored here: the pending result and counter are untouched.
                // cnt_q == 1 means this edge takes the counter to zero, which is the commit edge.
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!dz_q) begin
                        hi_d = hi_n_q;
                        lo_d = lo_n_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_n_q  <= '0;
            lo_n_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the launch edge T falls inside, returns at the negedge after T.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0BAD_F00D;
    endtask

    // Counts negedge samples with busy high, bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", LO); end
    endtask

    task automatic test_mult;
        int n;
        launch(3'd0, 32'hFFFF_FFFE, 32'd3);
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL mult_hi_old_during_run: got %h want 00000000", HI); end
        wait_idle(n);
        checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
    endtask

    task automatic test_multu;
        int n;
        launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo_old_during_run: got %h want fffffffa", LO); end
        wait_idle(n);
        checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
        checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
        checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", LO); end
    endtask

    task automatic test_div;
        int n;
        launch(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++; if (n != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
        launch(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++; if (n != 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 10", n); end
        checks++; if (LO !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo: got %h want 7ffffffc", LO); end
        checks++; if (HI !== 32'h0000_0001) begin errors++; $display("FAIL divu_hi: got %h want 00000001", HI); end
    endtask

    task automatic test_mthi_divzero;
        int n;
        launch(3'd4, 32'h1234_5678, 32'd0);
        checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", HI); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
        launch(3'd2, 32'd100, 32'd0);
        wait_idle(n);
        checks++; if (n != 10) begin errors++; $display("FAIL divzero_busy_cycles: got %0d want 10", n); end
        checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL divzero_hi: got %h want 12345678", HI); end
        checks++; if (LO !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divzero_lo: got %h want 7ffffffc", LO); end
        launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", LO); end
        checks++; if (HI !== 32'h0000_0000) begin errors++; $display("FAIL divovf_hi: got %h want 00000000", HI); end
    endtask

    task automatic test_mtlo_noop;
        launch(3'd5, 32'hCAFE_F00D, 32'd0);
        checks++; if (LO !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_lo: got %h want cafef00d", LO); end
        checks++; if (HI !== 32'h0000_0000) begin errors++; $display("FAIL mtlo_hi_kept: got %h want 00000000", HI); end
        launch(3'd6, 32'h5555_5555, 32'd7);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy: got %b want 0", busy); end
        checks++; if (LO !== 32'hCAFE_F00D) begin errors++; $display("FAIL noop_lo: got %h want cafef00d", LO); end
        checks++; if (HI !== 32'h0000_0000) begin errors++; $display("FAIL noop_hi: got %h want 00000000", HI); end
    endtask

    task automatic test_start_ignored;
        int n;
        int m;
        int rises;
        launch(3'd0, 32'd5, 32'd7);
        n = int'(busy);
        @(negedge clk);
        n += int'(busy);
        start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n += int'(busy);
        @(negedge clk);
        wait_idle(m);
        n += m;
        checks++; if (n != 5) begin errors++; $display("FAIL ignored_busy_cycles: got %0d want 5", n); end
        checks++; if (LO !== 32'd35) begin errors++; $display("FAIL ignored_lo: got %h want 00000023", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL ignored_hi: got %h want 00000000", HI); end
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b0) rises++;
            @(negedge clk);
        end
        checks++; if (rises != 0) begin errors++; $display("FAIL ignored_busy_refire: got %0d busy cycles want 0", rises); end
    endtask

    task automatic test_back_to_back;
        int n;
        launch(3'd1, 32'h0001_0000, 32'h0001_0000);
        for (int i = 0; i < 4; i++) @(negedge clk);
        // start lands on the commit edge T+5 and must be dropped
        start = 1'b1; MDOp = 3'd3; A = 32'd9; B = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_commit_edge_busy: got %b want 0", busy); end
        checks++; if (HI !== 32'd1 || LO !== 32'd0) begin errors++; $display("FAIL b2b_mult_result: got %h_%h want 00000001_00000000", HI, LO); end
        // edge T+6 is the first edge that accepts a new launch
        launch(3'd3, 32'd9, 32'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        wait_idle(n);
        checks++; if (n != 10) begin errors++; $display("FAIL b2b_divu_busy_cycles: got %0d want 10", n); end
        checks++; if (HI !== 32'd1 || LO !== 32'd4) begin errors++; $display("FAIL b2b_divu_result: got %h_%h want 00000001_00000004", HI, LO); end
    endtask

    task automatic test_reset_mid_run;
        int n;
        int bad;
        launch(3'd2, 32'd1000, 32'd7);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL midreset_hilo: got %h_%h want 00000000_00000000", HI, LO); end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midreset_late_commit: got %0d bad cycles want 0", bad); end
        launch(3'd0, 32'd6, 32'd7);
        wait_idle(n);
        checks++; if (n != 5) begin errors++; $display("FAIL postreset_mult_busy_cycles: got %0d want 5", n); end
        checks++; if (HI !== 32'd0 || LO !== 32'd42) begin errors++; $display("FAIL postreset_mult_result: got %h_%h want 00000000_0000002a", HI, LO); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        MDOp  = 3'd7;
        A     = 32'd0;
        B     = 32'd0;
        @(negedge clk);
        @(negedge clk);
        test_reset;
        reset = 1'b0;
        @(negedge clk);
        test_mult;
        test_multu;
        test_div;
        test_mthi_divzero;
        test_mtlo_noop;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
